wieg_regelaar: RTL
==================

Name: wieg_regelaar

Overview:
- Rocking-cradle controller, directly downstream of the stress evaluation stage.
- Consumes the per-evaluation verdicts gedaald (stress dropped) and gelijk (stress unchanged), sampled on the slow tick.
- Steps a rocking intensity level up, down or holds it, and drives the cradle motor with a PWM signal whose duty follows that level.

Parameters:
- MAX_LEVEL, 7: highest rocking level; levels run 0..MAX_LEVEL, and 0 means motor off.
- LVL_W, 3: width of the level; must satisfy 2^LVL_W > MAX_LEVEL.
- SETTLE_TICKS, 2: slow ticks ignored after every level change, while the stress measurement catches up.
- HOLD_TICKS, 4: consecutive "gedaald" verdicts in HOLD before the level is lowered by one.
- PWM_DIV, 16: clk cycles per PWM counter step.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- slow  in  1  one-clk-wide evaluation tick, the same tick that paces the stress stage
- aan  in  1  controller enable; low forces the motor off
- gedaald  in  1  stress decreased since the last evaluation; valid when slow=1
- gelijk  in  1  stress unchanged since the last evaluation; valid when slow=1
- niveau  out  LVL_W  current rocking level (registered)
- actief  out  1  high whenever the state is not IDLE (registered)
- pwm  out  1  motor drive (registered)

Behaviour:
- Clocking and reset:
  - One clock domain (clk). Reset is synchronous and active-high.
  - On reset: state=IDLE, niveau=0, actief=0, pwm=0, all counters 0.
- Input sampling:
  - gedaald and gelijk are sampled only in cycles where slow=1; otherwise they are don't-care.
  - Verdict decode per slow tick:
    - DOWN = gedaald (priority if both gedaald and gelijk are high)
    - SAME = gelijk & ~gedaald
    - UP = ~gedaald & ~gelijk
- State machine (transitions occur on slow=1 only, except the aan override):
  - IDLE:
    - If aan=1 on a slow tick: niveau<=1, settle_cnt<=0, go to SETTLE.
  - SETTLE:
    - settle_cnt increments each slow tick; verdicts are ignored.
    - When settle_cnt reaches SETTLE_TICKS-1 on a slow tick: go to EVAL.
  - EVAL:
    - DOWN: hold_cnt<=0, go to HOLD.
    - SAME: if niveau<MAX_LEVEL, niveau<=niveau+1 and go to SETTLE; at MAX_LEVEL, stay in EVAL.
    - UP: if niveau>1, niveau<=niveau-1 and go to SETTLE; at niveau=1, stay in EVAL.
  - HOLD:
    - DOWN: if hold_cnt==HOLD_TICKS-1, then niveau<=niveau-1 and hold_cnt<=0:
      - new niveau 0 goes to IDLE;
      - otherwise go to SETTLE.
    - DOWN otherwise: hold_cnt++.
    - SAME: no change.
    - UP: go to EVAL, level unchanged.
- aan override:
  - aan=0 in any cycle, regardless of slow: next cycle state=IDLE, niveau=0, counters cleared.
  - This takes priority over every transition.
- settle_cnt is reset to 0 on every entry into SETTLE.
- Latency:
  - niveau changes on the clk edge after the slow tick that triggers it.
  - actief=1 in the same cycle that niveau first becomes nonzero.
- PWM:
  - A prescaler counts 0..PWM_DIV-1. On wrap, pwm_cnt steps 0..MAX_LEVEL-1 and then wraps to 0.
  - pwm <= (pwm_cnt < applied_level), registered, so there is 1 cycle of latency.
  - Level 0 gives constant 0; MAX_LEVEL gives constant 1.
  - Level changes take effect at the next compare; the PWM counters are not reset.
- Reset mid-operation: behaves identically to power-up reset.

Optional Feature:
- Macro: WIEG_SOFTSTART_EN.
- With the macro defined:
  - applied_level is a separate register.
  - At each pwm_cnt wrap it moves one step toward niveau.
  - This gives a smooth motor ramp.
  - The aan=0 override still forces applied_level to 0 immediately.
- Without the macro: applied_level = niveau combinationally, with no ramp.

Decomposition:
- Package wieg_pkg holds:
  - the state enum (IDLE, SETTLE, EVAL, HOLD);
  - the default MAX_LEVEL and LVL_W constants;
  - the verdict enum (DOWN, SAME, UP).
- One sub-module, wieg_pwm, contains:
  - the prescaler;
  - pwm_cnt;
  - the optional soft-start register;
  - the comparator.
- The top level holds the FSM and its counters.

Test Plan:
- Start-up: reset, aan=1, first slow tick -> niveau=1, actief=1. 2 more slow ticks with any verdicts -> state EVAL, niveau still 1.
- Level climb: in EVAL, repeated SAME verdicts each followed by 2 settle ticks -> niveau steps 1,2,...,7 and saturates at 7 with no wrap. pwm is constant 1 at level 7.
- Calm-down: in EVAL at niveau=3, DOWN enters HOLD. 4 further DOWN ticks -> niveau=2 and SETTLE. Repeating until niveau=1 and then 4 DOWN ticks in HOLD -> niveau=0, IDLE, actief=0, pwm=0.
- Priority and stress rise:
  - gedaald=gelijk=1 in EVAL -> HOLD (DOWN wins).
  - UP in HOLD -> EVAL with niveau unchanged.
  - UP in EVAL at niveau=1 -> no change.
- Override: aan=0 mid-SETTLE at niveau=5, no slow pulse -> next cycle niveau=0, IDLE, pwm=0 within 2 cycles. With WIEG_SOFTSTART_EN, applied_level ramps 0→5 over 5 pwm_cnt wraps.
- PWM duty: niveau=3, PWM_DIV=16, MAX_LEVEL=7 -> pwm high for 48 of every 112 clk cycles. Reset asserted mid-period -> pwm=0 and counters 0 on the next cycle.

Source files
------------

// File: rtl/wieg_pkg.sv
// -----------------------------------------------------------------------------
// wieg_pkg
// Shared types and defaults for the rocking-cradle controller (wieg_regelaar).
//   state_e        : controller state (IDLE, SETTLE, EVAL, HOLD)
//   verdict_e      : decoded stress verdict per slow tick (DOWN, SAME, UP)
//   DEF_MAX_LEVEL  : default highest rocking level
//   DEF_LVL_W      : default level width (2**DEF_LVL_W > DEF_MAX_LEVEL)
//   decode_verdict : gedaald/gelijk -> verdict, gedaald has priority
// -----------------------------------------------------------------------------
package wieg_pkg;

    localparam int DEF_MAX_LEVEL = 7;
    localparam int DEF_LVL_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EVAL   = 2'd2,
        HOLD   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DOWN = 2'd0,
        SAME = 2'd1,
        UP   = 2'd2
    } verdict_e;

    // A falling stress level dominates: if both flags are set the baby is
    // calming down, so we treat it as DOWN.
    function automatic verdict_e decode_verdict(input logic gedaald, input logic gelijk);
        if (gedaald) begin
            return DOWN;
        end else if (gelijk) begin
            return SAME;
        end else begin
            return UP;
        end
    endfunction

endpackage

// File: rtl/wieg_regelaar_if.sv
// -----------------------------------------------------------------------------
// wieg_regelaar_if
// Signal bundle between the stress evaluation side and the cradle controller.
//   slow    : one-clk evaluation tick                (master -> slave)
//   aan     : controller enable, low forces motor off (master -> slave)
//   gedaald : stress dropped, valid with slow        (master -> slave)
//   gelijk  : stress unchanged, valid with slow      (master -> slave)
//   niveau  : current rocking level                  (slave -> master)
//   actief  : controller not idle                    (slave -> master)
//   pwm     : motor drive                            (slave -> master)
// Modports: master (stimulus / upstream side), slave (the controller).
// -----------------------------------------------------------------------------
interface wieg_regelaar_if #(
    parameter int LVL_W = 3
);
    logic             slow;
    logic             aan;
    logic             gedaald;
    logic             gelijk;
    logic [LVL_W-1:0] niveau;
    logic             actief;
    logic             pwm;

    modport master (
        output slow, aan, gedaald, gelijk,
        input  niveau, actief, pwm
    );

    modport slave (
        input  slow, aan, gedaald, gelijk,
        output niveau, actief, pwm
    );
endinterface

// File: rtl/wieg_pwm.sv
// -----------------------------------------------------------------------------
// wieg_pwm
// PWM generator for the cradle motor. A prescaler divides clk by PWM_DIV; each
// prescaler wrap advances pwm_cnt through 0..MAX_LEVEL-1. The output is high
// while pwm_cnt < applied level, registered (one cycle of latency).
// Optional: `WIEG_SOFTSTART_EN makes the applied level a register that moves
// one step toward level_i at every pwm_cnt wrap (soft motor ramp); force_off_i
// clears it at once. Without the macro the applied level is level_i itself.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   level_i     : requested rocking level
//   force_off_i : controller disabled (only used by the soft-start ramp)
//   pwm_o       : registered motor drive
// -----------------------------------------------------------------------------
module wieg_pwm
    import wieg_pkg::*;
#(
    parameter int MAX_LEVEL = DEF_MAX_LEVEL,
    parameter int LVL_W     = DEF_LVL_W,
    parameter int PWM_DIV   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LVL_W-1:0] level_i,
    input  logic             force_off_i,
    output logic             pwm_o
);

    localparam int               PW         = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PWM_DIV - 1);
    localparam logic [LVL_W-1:0] CNT_LAST   = LVL_W'(MAX_LEVEL - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [LVL_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             pwm_q, pwm_d;
    logic             step;
    logic             cnt_wrap;
    logic [LVL_W-1:0] applied_level;

    assign step     = (presc_q == PRESC_LAST);
    assign cnt_wrap = step && (pwm_cnt_q == CNT_LAST);

    // NOTE: every variable driven here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        presc_d   = step ? '0 : presc_q + PW'(1);
        pwm_cnt_d = pwm_cnt_q;
        if (step) begin
            pwm_cnt_d = cnt_wrap ? '0 : pwm_cnt_q + LVL_W'(1);
        end
    end

    // Level 0 never exceeds pwm_cnt (always low); MAX_LEVEL always does
    // (always high), since pwm_cnt tops out at MAX_LEVEL-1.
    assign pwm_d = (pwm_cnt_q < applied_level);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_q     <= pwm_d;
        end
    end

`ifdef WIEG_SOFTSTART_EN
    logic [LVL_W-1:0] applied_q;

    // Ramp one level per full PWM period so the motor never jumps in duty.
    always_ff @(posedge clk) begin
        if (reset || force_off_i) begin
            applied_q <= '0;
        end else if (cnt_wrap) begin
            if (applied_q < level_i) begin
                applied_q <= applied_q + LVL_W'(1);
            end else if (applied_q > level_i) begin
                applied_q <= applied_q - LVL_W'(1);
            end
        end
    end

    assign applied_level = applied_q;
`else
    // The controller already zeroes the level one cycle after aan drops,
    // so the direct path needs no separate force-off.
    logic unused_force_off;
    assign unused_force_off = force_off_i;
    assign applied_level    = level_i;
`endif

    assign pwm_o = pwm_q;

endmodule

// File: rtl/wieg_regelaar.sv
// -----------------------------------------------------------------------------
// wieg_regelaar
// Rocking-cradle controller. On every slow tick it reads the stress verdict
// (gedaald / gelijk) and steps the rocking level up, down or holds it, then
// drives the motor through wieg_pwm with a duty proportional to the level.
//   IDLE   : motor off; aan on a slow tick starts at level 1
//   SETTLE : SETTLE_TICKS slow ticks ignored after each level change
//   EVAL   : SAME -> level up, UP -> level down (min 1), DOWN -> HOLD
//   HOLD   : HOLD_TICKS consecutive DOWN verdicts lower the level by one
// aan=0 in any cycle returns to IDLE with level 0 on the next edge.
// Optional feature macro: WIEG_SOFTSTART_EN (soft PWM ramp in wieg_pwm).
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : wieg_regelaar_if.slave (slow, aan, gedaald, gelijk in;
//                niveau, actief, pwm out -- all outputs registered)
// -----------------------------------------------------------------------------
module wieg_regelaar
    import wieg_pkg::*;
#(
    parameter int MAX_LEVEL    = DEF_MAX_LEVEL,
    parameter int LVL_W        = DEF_LVL_W,
    parameter int SETTLE_TICKS = 2,
    parameter int HOLD_TICKS   = 4,
    parameter int PWM_DIV      = 16
) (
    input  logic           clk,
    input  logic           reset,
    wieg_regelaar_if.slave bus
);

    localparam int               SW          = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
    localparam int               HW          = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_TICKS - 1);
    localparam logic [HW-1:0]    HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [LVL_W-1:0] LVL_ONE     = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_MAX     = LVL_W'(MAX_LEVEL);

    state_e           state_q, state_d;
    logic [LVL_W-1:0] niveau_q, niveau_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic             actief_q;
    verdict_e         verdict;

    assign verdict = decode_verdict(bus.gedaald, bus.gelijk);

    always_comb begin
        state_d      = state_q;
        niveau_d     = niveau_q;
        settle_cnt_d = settle_cnt_q;
        hold_cnt_d   = hold_cnt_q;

        if (!bus.aan) begin
            // Disable wins over everything and does not wait for a tick.
            state_d      = IDLE;
            niveau_d     = '0;
            settle_cnt_d = '0;
            hold_cnt_d   = '0;
        end else if (bus.slow) begin
            unique case (state_q)
                IDLE: begin
                    state_d      = SETTLE;
                    niveau_d     = LVL_ONE;
                    settle_cnt_d = '0;
                end

                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = EVAL;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end

                EVAL: begin
                    case (verdict)
                        DOWN: begin
                            state_d    = HOLD;
                            hold_cnt_d = '0;
                        end
                        SAME: begin
                            // No improvement: rock harder, saturating at max.
                            if (niveau_q < LVL_MAX) begin
                                niveau_d     = niveau_q + LVL_ONE;
                                state_d      = SETTLE;
                                settle_cnt_d = '0;
                            end
                        end
                        default: begin
                            // UP: rocking is making it worse, back off but
                            // never switch off from here.
                            if (niveau_q > LVL_ONE) begin
                                niveau_d     = niveau_q - LVL_ONE;
                                state_d      = SETTLE;
                                settle_cnt_d = '0;
                            end
                        end
                    endcase
                end

                HOLD: begin
                    case (verdict)
                        DOWN: begin
                            if (hold_cnt_q == HOLD_LAST) begin
                                niveau_d   = niveau_q - LVL_ONE;
                                hold_cnt_d = '0;
                                if (niveau_q == LVL_ONE) begin
                                    state_d = IDLE;
                                end else begin
                                    state_d      = SETTLE;
                                    settle_cnt_d = '0;
                                end
                            end else begin
                                hold_cnt_d = hold_cnt_q + HW'(1);
                            end
                        end
                        SAME: begin
                            // Plateau: keep level and keep the DOWN count.
                        end
                        default: begin
                            state_d = EVAL;
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            niveau_q     <= '0;
            settle_cnt_q <= '0;
            hold_cnt_q   <= '0;
            actief_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            niveau_q     <= niveau_d;
            settle_cnt_q <= settle_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            // Derived from the next state so it rises with the first
            // nonzero level rather than a cycle later.
            actief_q     <= (state_d != IDLE);
        end
    end

    wieg_pwm #(
        .MAX_LEVEL (MAX_LEVEL),
        .LVL_W     (LVL_W),
        .PWM_DIV   (PWM_DIV)
    ) u_pwm (
        .clk         (clk),
        .reset       (reset),
        .level_i     (niveau_q),
        .force_off_i (~bus.aan),
        .pwm_o       (bus.pwm)
    );

    assign bus.niveau = niveau_q;
    assign bus.actief = actief_q;

endmodule
